// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Parametrised pipeline stage register carrying one packed
//             {ctrl, payload} bundle between stages. It provides valid/ready
//             flow control, hazard freeze, branch flush and an optional
//             two-entry skid buffer.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             flush                - drop held entries and the incoming beat
//             freeze               - hold state, block both sides
//             in_valid/in_ready    - upstream handshake
//             in_ctrl/in_data      - upstream control field / payload
//             out_valid/out_ready  - downstream handshake (head entry)
//             out_ctrl/out_data    - head control (masked) / payload
//             count                - number of held entries (0..SKID+1)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 96,
  parameter int SKID   = 0,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] c_CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_TWO  = CNT_W'(2);

  // Entry 0 is always the head; entry 1 is only used with the skid buffer.
  logic [CTRL_W-1:0] ctrl_q [2];
  logic [CTRL_W-1:0] ctrl_d [2];
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  logic w_room;
  logic w_push;
  logic w_pop;

  generate
    if (SKID == 0) begin : g_single
      // A full single entry can still accept when the head leaves this cycle.
      assign w_room = (count_q == c_CNT_ZERO) | out_ready;
    end else begin : g_skid
      // Ready depends only on held occupancy, breaking the out_ready path.
      assign w_room = (count_q < c_CNT_TWO);
    end
  endgenerate

  assign in_ready  = ~rst & ~freeze & w_room;
  assign out_valid = ~freeze & (count_q != c_CNT_ZERO);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_ctrl  = out_valid ? ctrl_q[0] : '0;
  assign out_data  = data_q[0];
  assign count     = count_q;

  always_comb begin
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    count_d = count_q;
    if (flush) begin
      ctrl_d  = '{default: '0};
      data_d  = '{default: '0};
      count_d = c_CNT_ZERO;
    end else if (SKID == 0) begin
      if (w_push) begin
        ctrl_d[0] = in_ctrl;
        data_d[0] = in_data;
        count_d   = c_CNT_ONE;
      end else if (w_pop) begin
        count_d   = c_CNT_ZERO;
      end
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (count_q == c_CNT_ZERO) begin
            ctrl_d[0] = in_ctrl;
            data_d[0] = in_data;
            count_d   = c_CNT_ONE;
          end else begin
            ctrl_d[1] = in_ctrl;
            data_d[1] = in_data;
            count_d   = c_CNT_TWO;
          end
        end
        2'b01: begin
          // Shift only when a second entry exists; a lone head stays put so
          // out_data keeps its last value once the stage drains.
          if (count_q == c_CNT_TWO) begin
            ctrl_d[0] = ctrl_q[1];
            data_d[0] = data_q[1];
          end
          count_d = count_q - c_CNT_ONE;
        end
        2'b11: begin
          // Only reachable with one entry held: head replaced in place.
          ctrl_d[0] = in_ctrl;
          data_d[0] = in_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        ctrl_q[i] <= '0;
        data_q[i] <= '0;
      end
      count_q <= c_CNT_ZERO;
    end else begin
      for (int i = 0; i < 2; i++) begin
        ctrl_q[i] <= ctrl_d[i];
        data_q[i] <= data_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Self-checking bench for pipe_stage_reg. Drives one SKID=0 and
//             one SKID=1 instance from shared stimulus and compares every
//             output each cycle with a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int CW = 4;
  localparam int DW = 96;
  localparam int BW = CW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, freeze, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          ir0, ov0, ir1, ov1;
  logic [CW-1:0] oc0, oc1;
  logic [DW-1:0] od0, od1;
  logic [1:0]    cnt0, cnt1;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(2)) u_single (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
    .count(cnt0)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(2)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
    .count(cnt1)
  );

  // Reference model: a FIFO of beats per instance plus the payload left
  // visible on out_data once the stage has drained.
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  logic [DW-1:0] stale [2];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  armed    = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic step();
    int            sz;
    logic [BW-1:0] head;
    logic          eir, eov;
    logic [CW-1:0] eoc;
    bit            pu [2];
    bit            po [2];
    logic [BW-1:0] hd [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sz   = (k == 0) ? q0.size() : q1.size();
      head = (sz > 0) ? ((k == 0) ? q0[0] : q1[0]) : {{CW{1'b0}}, stale[k]};
      eir  = !rst && !freeze && ((k == 1) ? (sz < 2) : (sz == 0 || out_ready));
      eov  = !freeze && (sz > 0);
      eoc  = eov ? head[BW-1:DW] : '0;
      if (armed) begin
        chk($sformatf("in_ready skid%0d t=%0t", k, $time),
            128'((k == 0) ? ir0 : ir1), 128'(eir));
        chk($sformatf("out_valid skid%0d t=%0t", k, $time),
            128'((k == 0) ? ov0 : ov1), 128'(eov));
        chk($sformatf("out_ctrl skid%0d t=%0t", k, $time),
            128'((k == 0) ? oc0 : oc1), 128'(eoc));
        chk($sformatf("out_data skid%0d t=%0t", k, $time),
            128'((k == 0) ? od0 : od1), 128'(head[DW-1:0]));
        chk($sformatf("count skid%0d t=%0t", k, $time),
            128'((k == 0) ? cnt0 : cnt1), 128'(sz));
      end
      pu[k] = in_valid && eir;
      po[k] = eov && out_ready;
      hd[k] = head;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst || flush) begin
        if (k == 0) q0.delete(); else q1.delete();
        stale[k] = '0;
      end else begin
        if (po[k]) begin
          stale[k] = hd[k][DW-1:0];
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (pu[k]) begin
          if (k == 0) q0.push_back({in_ctrl, in_data});
          else        q1.push_back({in_ctrl, in_data});
        end
      end
    end
    if (rst) armed = 1'b1;
    #1;
  endtask

  initial begin
    stale[0] = '0;
    stale[1] = '0;
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    drive(1'b1, 4'h5, 96'h55, 1'b0);

    // Reset held two cycles with a valid beat offered.
    step(); step();
    rst = 1'b0;

    // Single beat, one-cycle latency, then drain.
    drive(1'b1, 4'hA, 96'h123, 1'b1); step();
    drive(1'b0, 4'h0, 96'h0, 1'b1);   step(); step();

    // Backpressure: three beats offered, skid holds two.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 4'(i), 96'(i), 1'b0); step();
    end
    drive(1'b1, 4'h3, 96'h3, 1'b1);
    for (int i = 0; i < 4; i++) step();
    drive(1'b0, 4'h0, 96'h0, 1'b1);
    for (int i = 0; i < 3; i++) step();

    // Preload a beat, then stream ten beats with the sink always ready.
    drive(1'b1, 4'hF, 96'hFF, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i), 96'(i), 1'b1); step();
    end
    drive(1'b0, 4'h0, 96'h0, 1'b1); step(); step();

    // Fill, then flush with a concurrent incoming beat.
    drive(1'b1, 4'h1, 96'hAAA, 1'b0); step();
    drive(1'b1, 4'h2, 96'hBBB, 1'b0); step();
    flush = 1'b1;
    drive(1'b1, 4'h3, 96'hCCC, 1'b1); step();
    flush = 1'b0;
    drive(1'b0, 4'h0, 96'h0, 1'b1); step(); step();

    // One entry held, freeze for three cycles, then release.
    drive(1'b1, 4'h9, 96'hD00D, 1'b0); step();
    freeze = 1'b1;
    drive(1'b1, 4'h7, 96'hBEEF, 1'b1);
    for (int i = 0; i < 3; i++) step();
    freeze = 1'b0;
    drive(1'b0, 4'h0, 96'h0, 1'b1);
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      flush  = ($urandom_range(0, 39) == 0);
      freeze = ($urandom_range(0, 6) == 0);
      drive(($urandom_range(0, 9) < 6), 4'($urandom),
            {$urandom, $urandom, $urandom}, ($urandom_range(0, 9) < 6));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
